tx_shift_ctrl: RTL and testbench

Control stage that sits directly upstream of the flexible parallel-to-serial shift register. It accepts one NUM_BITS word per valid/ready handshake and holds it for the register's parallel input. It then drives the register's load and shift strobes so that each bit is presented on serial_out for exactly BIT_PERIOD clock cycles. It flags the end of each frame to the surrounding JTAG/serial logic.

---
 rtl/tx_shift_ctrl.sv | 116 +++++++++++
 tb/tb_tx_shift_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tx_shift_ctrl.sv
// rtl/tx_shift_ctrl.sv - load/shift strobe controller for a parallel-to-serial shift register
// Optional macro TX_SHIFT_CTRL_BACK2BACK_EN: accept the next word in DONE for gapless frames.
module tx_shift_ctrl #(
  parameter int NUM_BITS   = 8,
  parameter int BIT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                load_enable,
  output logic                shift_enable,
  output logic                busy,
  output logic                frame_done
);

  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PW-1:0]       period_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [NUM_BITS-1:0] hold;
  logic                accept;
  logic                period_end;
  logic                last_bit;

  assign accept       = tx_valid && tx_ready;
  assign period_end   = (state == S_SHIFT) && (period_cnt == PERIOD_LAST);
  assign last_bit     = (bit_cnt == BIT_LAST);
  assign parallel_out = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      period_cnt <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        hold <= tx_data;
      end
      // Counters only run in SHIFT; every other state leaves them cleared for the next frame.
      if (state == S_SHIFT) begin
        if (period_end) begin
          period_cnt <= '0;
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          period_cnt <= period_cnt + 1'b1;
        end
      end else begin
        period_cnt <= '0;
        bit_cnt    <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_LOAD;
      S_LOAD:  state_next = S_SHIFT;
      S_SHIFT: if (period_end && last_bit) state_next = S_DONE;
      S_DONE: begin
`ifdef TX_SHIFT_CTRL_BACK2BACK_EN
        state_next = accept ? S_LOAD : S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready     = 1'b0;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;
    case (state)
      S_IDLE: tx_ready = 1'b1;
      S_LOAD: begin
        load_enable = 1'b1;
        busy        = 1'b1;
      end
      S_SHIFT: begin
        busy         = 1'b1;
        shift_enable = period_end && !last_bit;
      end
      S_DONE: begin
        frame_done = 1'b1;
`ifdef TX_SHIFT_CTRL_BACK2BACK_EN
        tx_ready   = 1'b1;
`endif
      end
      default: tx_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_tx_shift_ctrl.sv
// tb/tb_tx_shift_ctrl.sv - directed bench for tx_shift_ctrl with attached MSB-first shift register models
module tb_tx_shift_ctrl;

`ifdef TX_SHIFT_CTRL_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, load_enable, shift_enable, busy, frame_done;
  logic [7:0] parallel_out;

  logic       tx_valid2 = 1'b0;
  logic [3:0] tx_data2 = 4'h0;
  logic       tx_ready2, load_enable2, shift_enable2, busy2, frame_done2;
  logic [3:0] parallel_out2;

  logic [7:0] sr;
  logic [3:0] sr2;
  logic [7:0] pat;
  logic [3:0] pat2;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  tx_shift_ctrl #(.NUM_BITS(8), .BIT_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .parallel_out(parallel_out), .load_enable(load_enable), .shift_enable(shift_enable),
    .busy(busy), .frame_done(frame_done)
  );

  tx_shift_ctrl #(.NUM_BITS(4), .BIT_PERIOD(1)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .parallel_out(parallel_out2), .load_enable(load_enable2), .shift_enable(shift_enable2),
    .busy(busy2), .frame_done(frame_done2)
  );

  // External MSB-first shift registers driven by the controller strobes.
  always @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      sr2 <= '0;
    end else begin
      if (load_enable) sr <= parallel_out;
      else if (shift_enable) sr <= {sr[6:0], 1'b0};
      if (load_enable2) sr2 <= parallel_out2;
      else if (shift_enable2) sr2 <= {sr2[2:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset held two cycles with a pending word
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_flags", {tx_ready, load_enable, shift_enable, busy, frame_done}, 5'b10000);
    check("rst_par", parallel_out, 8'h00);
    check("rst_flags2", {tx_ready2, load_enable2, shift_enable2, busy2, frame_done2}, 5'b10000);
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    check("rst_noaccept", {busy, parallel_out}, 9'h000);

    // 0xA5 frame with tx_data churning underneath
    pat = 8'hA5;
    tx_valid = 1'b1; tx_data = 8'hA5;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      check($sformatf("a_load_c%0d", c), load_enable, (c == 1) || (B2B && c == 35));
      check($sformatf("a_shift_c%0d", c), shift_enable, (c >= 5 && c <= 29 && (c - 1) % 4 == 0));
      check($sformatf("a_done_c%0d", c), frame_done, (c == 34));
      check($sformatf("a_busy_c%0d", c), busy, (c <= 33) || (B2B && c == 35));
      check($sformatf("a_ready_c%0d", c), tx_ready, (c == 34) ? B2B : (c == 35) ? !B2B : 1'b0);
      check($sformatf("a_par_c%0d", c), parallel_out, (c == 35 && B2B) ? 8'h5A : 8'hA5);
      if (c >= 2 && c <= 33)
        check($sformatf("a_ser_c%0d", c), sr[7], pat[7 - (c - 2) / 4]);
      tx_data = (c >= 34) ? 8'h5A : 8'((c * 29 + 3) & 8'hFF);
    end
    @(negedge clk);
    check("a_next_par", parallel_out, 8'h5A);
    check("a_next_load", load_enable, !B2B);
    tx_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset in cycle 10 aborts the frame
    tx_valid = 1'b1; tx_data = 8'hC3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
      if (c == 5) check("r_shift_c5", shift_enable, 1'b1);
      if (c == 10) rst = 1'b1;
    end
    for (int c = 11; c <= 50; c++) begin
      @(negedge clk);
      rst = 1'b0;
      check($sformatf("r_quiet_c%0d", c), {busy, tx_ready, shift_enable, frame_done, load_enable}, 5'b01000);
      if (c == 11) check("r_par", parallel_out, 8'h00);
    end

`ifdef TX_SHIFT_CTRL_BACK2BACK_EN
    // 0xFF then 0x00 with no gap
    tx_valid = 1'b1; tx_data = 8'hFF;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c == 34) check("b_ready_c34", {tx_ready, frame_done}, 2'b11);
      if (c == 35) check("b_load_c35", {load_enable, tx_ready}, 2'b10);
      if (c == 68) check("b_done_c68", frame_done, 1'b1);
      if (c >= 2 && c <= 33) check($sformatf("b_ser1_c%0d", c), sr[7], 1'b1);
      if (c >= 36 && c <= 67) check($sformatf("b_ser0_c%0d", c), sr[7], 1'b0);
      if (c == 34) tx_data = 8'h00;
      if (c == 35) tx_valid = 1'b0;
    end
    @(negedge clk);
`endif

    // NUM_BITS=4, BIT_PERIOD=1 instance sends 0x9
    pat2 = 4'h9;
    tx_valid2 = 1'b1; tx_data2 = 4'h9;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      tx_valid2 = 1'b0;
      check($sformatf("s_load_c%0d", c), load_enable2, (c == 1));
      check($sformatf("s_shift_c%0d", c), shift_enable2, (c >= 2 && c <= 4));
      check($sformatf("s_done_c%0d", c), frame_done2, (c == 6));
      check($sformatf("s_ready_c%0d", c), tx_ready2, (c == 7));
      if (c >= 2 && c <= 5) check($sformatf("s_ser_c%0d", c), sr2[3], pat2[3 - (c - 2)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
